// File: rtl/lcd_fb_sched.sv
// Triple-buffer bank scheduler between the PPU pixel writer and video scan-out.
// Hands the writer a free bank and the reader the newest complete frame,
// dropping or repeating frames on rate mismatch and blanking across LCD off/on.
module lcd_fb_sched #(
  parameter int unsigned FRAME_PIX = 23040,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              lcd_on,
  input  logic              wr_pix,
  input  logic              wr_frame_end,
  input  logic              rd_frame_start,
  input  logic              rd_pix,
  output logic              wr_we,
  output logic [1:0]        wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_blank,
  output logic              rd_repeat,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W-1:0] WR_SAT = ADDR_W'(FRAME_PIX);
  localparam logic [ADDR_W-1:0] RD_SAT = ADDR_W'(FRAME_PIX - 1);

  typedef enum logic [1:0] {W_OFF, W_SKIP, W_ACTIVE} wstate_t;

  wstate_t     state, state_nxt;
  logic        lcd_on_d;
  logic        lcd_rise, lcd_fall;
  logic        wr_full;
  logic        commit;
  logic [1:0]  ready_bank;
  logic        ready_valid, blank_pending;

  logic [1:0]  wr_bank_nxt, rd_bank_nxt, ready_bank_nxt;
  logic        ready_valid_nxt, blank_pending_nxt;
  logic        rd_blank_nxt, rd_repeat_nxt;

  assign lcd_rise = lcd_on & ~lcd_on_d;
  assign lcd_fall = ~lcd_on & lcd_on_d;
  assign wr_full  = (wr_addr == WR_SAT);
  // A falling lcd_on in the same cycle suppresses the commit.
  assign commit   = (state == W_ACTIVE) & wr_frame_end & wr_full & ~lcd_fall;

  // lcd_on delay register for edge detection
  always_ff @(posedge clk_sys) begin
    if (reset) lcd_on_d <= 1'b0;
    else       lcd_on_d <= lcd_on;
  end

  // Writer FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= W_OFF;
    else       state <= state_nxt;
  end

  // Writer FSM next state and RAM write enable
  always_comb begin
    state_nxt = state;
    wr_we     = 1'b0;
    if (lcd_fall) begin
      state_nxt = W_OFF;
    end else begin
      case (state)
        W_OFF:    if (lcd_rise) state_nxt = W_SKIP;
        W_SKIP:   if (wr_frame_end) state_nxt = W_ACTIVE;
        W_ACTIVE: state_nxt = W_ACTIVE;
        default:  state_nxt = W_OFF;
      endcase
    end
    // Frame end and LCD-off take precedence over a coincident pixel.
    if (!reset && state == W_ACTIVE && wr_pix && !wr_frame_end && !lcd_fall && !wr_full)
      wr_we = 1'b1;
  end

  // Bank rotation: commit resolves first, then the reader takes what is ready
  always_comb begin
    wr_bank_nxt       = wr_bank;
    rd_bank_nxt       = rd_bank;
    ready_bank_nxt    = ready_bank;
    ready_valid_nxt   = ready_valid;
    blank_pending_nxt = blank_pending;
    rd_blank_nxt      = rd_blank;
    rd_repeat_nxt     = rd_repeat;
    if (lcd_fall) begin
      ready_valid_nxt   = 1'b0;
      blank_pending_nxt = 1'b1;
    end else if (commit) begin
      wr_bank_nxt       = ready_bank;
      ready_bank_nxt    = wr_bank;
      ready_valid_nxt   = 1'b1;
      blank_pending_nxt = 1'b0;
    end
    if (rd_frame_start) begin
      rd_blank_nxt = blank_pending_nxt;
      if (ready_valid_nxt) begin
        rd_bank_nxt     = ready_bank_nxt;
        ready_bank_nxt  = rd_bank;
        ready_valid_nxt = 1'b0;
        rd_repeat_nxt   = 1'b0;
      end else begin
        rd_repeat_nxt   = 1'b1;
      end
    end
  end

  // Bank, flag and drop counter registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_bank       <= 2'd0;
      ready_bank    <= 2'd1;
      rd_bank       <= 2'd2;
      ready_valid   <= 1'b0;
      blank_pending <= 1'b1;
      rd_blank      <= 1'b1;
      rd_repeat     <= 1'b0;
      drop_cnt      <= 8'd0;
    end else begin
      wr_bank       <= wr_bank_nxt;
      ready_bank    <= ready_bank_nxt;
      rd_bank       <= rd_bank_nxt;
      ready_valid   <= ready_valid_nxt;
      blank_pending <= blank_pending_nxt;
      rd_blank      <= rd_blank_nxt;
      rd_repeat     <= rd_repeat_nxt;
      if (commit && ready_valid && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Write pixel index: cleared on LCD off and frame end, saturating count
  always_ff @(posedge clk_sys) begin
    if (reset)                                     wr_addr <= '0;
    else if (lcd_fall || wr_frame_end)             wr_addr <= '0;
    else if (wr_pix && state != W_OFF && !wr_full) wr_addr <= wr_addr + ADDR_W'(1);
  end

  // Read pixel index: cleared on frame start, saturating at last pixel
  always_ff @(posedge clk_sys) begin
    if (reset)                            rd_addr <= '0;
    else if (rd_frame_start)              rd_addr <= '0;
    else if (rd_pix && rd_addr != RD_SAT) rd_addr <= rd_addr + ADDR_W'(1);
  end

endmodule

// File: tb/tb_lcd_fb_sched.sv
// Directed scoreboard bench for lcd_fb_sched (small frame size for run time).
module tb_lcd_fb_sched;

  localparam int unsigned FP = 64;
  localparam int unsigned AW = 15;

  logic          clk_sys = 1'b0;
  logic          reset, lcd_on, wr_pix, wr_frame_end, rd_frame_start, rd_pix;
  logic          wr_we;
  logic [1:0]    wr_bank, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          rd_blank, rd_repeat;
  logic [7:0]    drop_cnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  lcd_fb_sched #(.FRAME_PIX(FP), .ADDR_W(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .lcd_on(lcd_on), .wr_pix(wr_pix),
    .wr_frame_end(wr_frame_end), .rd_frame_start(rd_frame_start), .rd_pix(rd_pix),
    .wr_we(wr_we), .wr_bank(wr_bank), .wr_addr(wr_addr), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_blank(rd_blank), .rd_repeat(rd_repeat), .drop_cnt(drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic exp_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic pix(input int n);
    wr_pix = 1'b1;
    repeat (n) tick();
    wr_pix = 1'b0;
  endtask

  task automatic wfe();
    wr_frame_end = 1'b1;
    tick();
    wr_frame_end = 1'b0;
  endtask

  task automatic rfs();
    rd_frame_start = 1'b1;
    tick();
    rd_frame_start = 1'b0;
  endtask

  task automatic frame();
    pix(FP);
    wfe();
  endtask

  initial begin
    reset = 1'b1; lcd_on = 1'b0; wr_pix = 1'b0; wr_frame_end = 1'b0;
    rd_frame_start = 1'b0; rd_pix = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    exp_v("rst_wr_bank", 0);  exp_v("rst_rd_bank", 2);  exp_v("rst_wr_addr", 0);
    exp_v("rst_rd_addr", 0);  exp_v("rst_rd_blank", 1); exp_v("rst_rd_repeat", 0);
    exp_v("rst_drop", 0);     exp_v("rst_wr_we", 0);
    check(32'(wr_bank));  check(32'(rd_bank));  check(32'(wr_addr));
    check(32'(rd_addr));  check(32'(rd_blank)); check(32'(rd_repeat));
    check(32'(drop_cnt)); check(32'(wr_we));

    // Normal flow: enable, skipped frame, then first committed frame
    lcd_on = 1'b1;
    tick();
    wr_pix = 1'b1;
    exp_v("skip_wr_we", 0);
    #1 check(32'(wr_we));
    pix(FP);
    exp_v("skip_wr_addr", FP);
    check(32'(wr_addr));
    rd_pix = 1'b1;
    repeat (FP + 3) tick();
    rd_pix = 1'b0;
    exp_v("rd_addr_sat", FP - 1);
    check(32'(rd_addr));
    exp_v("skip_end_wr_addr", 0); exp_v("skip_end_wr_bank", 0);
    wfe();
    check(32'(wr_addr)); check(32'(wr_bank));
    exp_v("first_rd_repeat", 1); exp_v("first_rd_bank", 2);
    exp_v("first_rd_blank", 1);  exp_v("first_rd_addr", 0);
    rfs();
    check(32'(rd_repeat)); check(32'(rd_bank)); check(32'(rd_blank)); check(32'(rd_addr));
    wr_pix = 1'b1;
    exp_v("active_wr_we", 1);
    #1 check(32'(wr_we));
    exp_v("commit1_wr_bank", 1);
    frame();
    check(32'(wr_bank));
    exp_v("read1_rd_bank", 0); exp_v("read1_rd_repeat", 0); exp_v("read1_rd_blank", 0);
    rfs();
    check(32'(rd_bank)); check(32'(rd_repeat)); check(32'(rd_blank));

    // Writer faster than reader
    exp_v("fast_wr_drop", 2); exp_v("fast_wr_bank", 2);
    repeat (3) frame();
    check(32'(drop_cnt)); check(32'(wr_bank));
    exp_v("fast_wr_rd_bank", 1); exp_v("fast_wr_rd_repeat", 0);
    rfs();
    check(32'(rd_bank)); check(32'(rd_repeat));

    // Reader faster than writer
    frame();
    exp_v("fast_rd_bank1", 2); exp_v("fast_rd_repeat1", 0);
    rfs();
    check(32'(rd_bank)); check(32'(rd_repeat));
    exp_v("fast_rd_bank2", 2); exp_v("fast_rd_repeat2", 1);
    rfs();
    check(32'(rd_bank)); check(32'(rd_repeat));

    // Simultaneous commit and frame start with nothing ready
    pix(FP);
    exp_v("sim_rd_bank", 0); exp_v("sim_wr_bank", 1); exp_v("sim_rd_repeat", 0);
    exp_v("sim_drop", 2);    exp_v("sim_rd_blank", 0);
    wr_frame_end = 1'b1; rd_frame_start = 1'b1;
    tick();
    wr_frame_end = 1'b0; rd_frame_start = 1'b0;
    check(32'(rd_bank)); check(32'(wr_bank)); check(32'(rd_repeat));
    check(32'(drop_cnt)); check(32'(rd_blank));
    exp_v("sim_after_repeat", 1); exp_v("sim_after_rd_bank", 0);
    rfs();
    check(32'(rd_repeat)); check(32'(rd_bank));

    // Short frame leaves ready frame intact; frame end beats a coincident pixel
    exp_v("short_pre_wr_bank", 2);
    frame();
    check(32'(wr_bank));
    pix(10);
    exp_v("short_wr_addr", 10);
    check(32'(wr_addr));
    wr_pix = 1'b1; wr_frame_end = 1'b1;
    exp_v("pix_fe_wr_we", 0);
    #1 check(32'(wr_we));
    exp_v("short_end_wr_addr", 0); exp_v("short_wr_bank", 2); exp_v("short_drop", 2);
    tick();
    wr_pix = 1'b0; wr_frame_end = 1'b0;
    check(32'(wr_addr)); check(32'(wr_bank)); check(32'(drop_cnt));
    exp_v("short_rd_bank", 1); exp_v("short_rd_repeat", 0);
    rfs();
    check(32'(rd_bank)); check(32'(rd_repeat));

    // LCD off mid-frame, then on again
    exp_v("off_pre_wr_bank", 0);
    frame();
    check(32'(wr_bank));
    pix(5);
    lcd_on = 1'b0;
    exp_v("off_wr_addr", 0);
    tick();
    check(32'(wr_addr));
    wr_pix = 1'b1;
    exp_v("off_wr_we", 0);
    #1 check(32'(wr_we));
    wr_pix = 1'b0;
    exp_v("off_rd_repeat", 1); exp_v("off_rd_bank", 1); exp_v("off_rd_blank", 1);
    rfs();
    check(32'(rd_repeat)); check(32'(rd_bank)); check(32'(rd_blank));
    lcd_on = 1'b1;
    tick();
    pix(FP + 1);
    exp_v("reon_skip_wr_addr", FP);
    check(32'(wr_addr));
    wfe();
    exp_v("reon_skip_rd_blank", 1); exp_v("reon_skip_rd_repeat", 1);
    rfs();
    check(32'(rd_blank)); check(32'(rd_repeat));
    pix(FP);
    wr_pix = 1'b1;
    exp_v("sat_last_wr_we", 0);
    #1 check(32'(wr_we));
    tick();
    wr_pix = 1'b0;
    exp_v("sat_wr_addr", FP);
    check(32'(wr_addr));
    exp_v("reon_commit_wr_bank", 2); exp_v("reon_commit_drop", 2);
    wfe();
    check(32'(wr_bank)); check(32'(drop_cnt));
    exp_v("reon_rd_bank", 0); exp_v("reon_rd_blank", 0); exp_v("reon_rd_repeat", 0);
    rfs();
    check(32'(rd_bank)); check(32'(rd_blank)); check(32'(rd_repeat));

    // Drop counter saturation
    exp_v("drop_sat", 255);
    repeat (260) frame();
    check(32'(drop_cnt));

    // Reset overrides coincident strobes
    wr_pix = 1'b1; wr_frame_end = 1'b1; rd_frame_start = 1'b1; reset = 1'b1;
    exp_v("mid_rst_wr_bank", 0); exp_v("mid_rst_rd_bank", 2); exp_v("mid_rst_wr_addr", 0);
    exp_v("mid_rst_drop", 0);    exp_v("mid_rst_rd_blank", 1); exp_v("mid_rst_rd_repeat", 0);
    tick();
    wr_pix = 1'b0; wr_frame_end = 1'b0; rd_frame_start = 1'b0; reset = 1'b0;
    check(32'(wr_bank)); check(32'(rd_bank)); check(32'(wr_addr));
    check(32'(drop_cnt)); check(32'(rd_blank)); check(32'(rd_repeat));

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
